// File: rtl/dbf_add_tree.sv
// Registered binary adder tree that sums N_CH enabled two's-complement channels.
// The full sum is scaled by an arithmetic right shift and saturated to OUT_W bits.
module dbf_add_tree #(
  parameter int N_CH  = 24,
  parameter int IN_W  = 32,
  parameter int OUT_W = 37,
  parameter int SHIFT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_CH*IN_W-1:0]   data_in,
  input  logic [N_CH-1:0]        ch_en,
  input  logic                   in_valid,
  output logic [OUT_W-1:0]       data_add_out,
  output logic                   out_valid,
  output logic                   sat,
  output logic [15:0]            sat_cnt
);

  localparam int L      = $clog2(N_CH);
  localparam int FULL_W = IN_W + L;
  localparam int CMP_W  = (FULL_W > OUT_W) ? FULL_W : OUT_W;

  localparam logic signed [CMP_W-1:0] OUT_MAX = {{(CMP_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [CMP_W-1:0] OUT_MIN = {{(CMP_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  // Level 0 holds the masked inputs; level l holds ceil(N_CH / 2^l) partial sums.
  // Entry N_CH is a constant-zero pad so pair indices never leave the array.
  logic signed [FULL_W-1:0] tree [0:L][0:N_CH];
  logic [L:0]               vld;

  function automatic int lvl_cnt(input int l);
    return (N_CH + (1 << l) - 1) >> l;
  endfunction

  function automatic int clamp_idx(input int i);
    return (i > N_CH) ? N_CH : i;
  endfunction

  // NOTE: the tree array is reset as well, so a mid-stream reset leaves no stale partial sums.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int l = 0; l <= L; l++) begin
        for (int j = 0; j <= N_CH; j++) begin
          tree[l][j] <= '0;
        end
      end
    end else begin
      // NOTE: non-blocking assignments let every level read the previous level's old contents.
      vld <= {vld[L-1:0], in_valid};
      for (int j = 0; j < N_CH; j++) begin
        tree[0][j] <= ch_en[j] ? FULL_W'(signed'(data_in[j*IN_W +: IN_W])) : '0;
      end
      tree[0][N_CH] <= '0;
      for (int l = 1; l <= L; l++) begin
        for (int j = 0; j <= N_CH; j++) begin
          if (j < lvl_cnt(l)) begin
            if (2*j + 1 < lvl_cnt(l-1))
              tree[l][j] <= tree[l-1][clamp_idx(2*j)] + tree[l-1][clamp_idx(2*j+1)];
            else
              tree[l][j] <= tree[l-1][clamp_idx(2*j)];
          end else begin
            tree[l][j] <= '0;
          end
        end
      end
    end
  end

  logic signed [FULL_W-1:0] sum_sh;
  logic signed [CMP_W-1:0]  sum_ext;
  logic [OUT_W-1:0]         res_next;
  logic                     sat_next;

  // NOTE: every output of this block is given a default first, so no latch can be inferred.
  always_comb begin
    sum_sh   = tree[L][0] >>> SHIFT;
    sum_ext  = CMP_W'(sum_sh);
    res_next = sum_ext[OUT_W-1:0];
    sat_next = 1'b0;
    if (sum_ext > OUT_MAX) begin
      res_next = OUT_MAX[OUT_W-1:0];
      sat_next = 1'b1;
    end else if (sum_ext < OUT_MIN) begin
      res_next = OUT_MIN[OUT_W-1:0];
      sat_next = 1'b1;
    end
  end

  // Result and flag only move on a valid final-stage word; otherwise they hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      data_add_out <= '0;
      sat          <= 1'b0;
      sat_cnt      <= '0;
    end else begin
      out_valid <= vld[L];
      if (vld[L]) begin
        data_add_out <= res_next;
        sat          <= sat_next;
        if (sat_next && sat_cnt != 16'hFFFF)
          sat_cnt <= sat_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dbf_add_tree.sv
// Self-checking bench for dbf_add_tree: a default 24-channel instance and two
// 5-channel instances (SHIFT 0 and 3) checked every cycle against an arithmetic model.
module tb_dbf_add_tree;

  typedef logic signed [63:0] val_t;
  typedef struct {
    int   due;
    val_t val;
    bit   sat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [767:0] data_in;
  logic [23:0]  ch_en;
  logic         in_valid;
  logic [36:0]  dout0;
  logic         ov0, sat0;
  logic [15:0]  scnt_dut0;

  logic [159:0] data5;
  logic [4:0]   en5;
  logic         iv5;
  logic [31:0]  dout1, dout2;
  logic         ov1, ov2, sat1, sat2;
  logic [15:0]  scnt_dut1, scnt_dut2;

  dbf_add_tree dut0 (
    .clk(clk), .rst(rst), .data_in(data_in), .ch_en(ch_en), .in_valid(in_valid),
    .data_add_out(dout0), .out_valid(ov0), .sat(sat0), .sat_cnt(scnt_dut0)
  );

  dbf_add_tree #(.N_CH(5), .IN_W(32), .OUT_W(32), .SHIFT(0)) dut1 (
    .clk(clk), .rst(rst), .data_in(data5), .ch_en(en5), .in_valid(iv5),
    .data_add_out(dout1), .out_valid(ov1), .sat(sat1), .sat_cnt(scnt_dut1)
  );

  dbf_add_tree #(.N_CH(5), .IN_W(32), .OUT_W(32), .SHIFT(3)) dut2 (
    .clk(clk), .rst(rst), .data_in(data5), .ch_en(en5), .in_valid(iv5),
    .data_add_out(dout2), .out_valid(ov2), .sat(sat2), .sat_cnt(scnt_dut2)
  );

  exp_t q0[$], q1[$], q2[$];
  int   cycle = 0;
  int   n_checks = 0, n_pass = 0, n_fail = 0;
  val_t last0 = 0, last1 = 0, last2 = 0;
  bit   lsat0 = 0, lsat1 = 0, lsat2 = 0;
  int   mcnt0 = 0, mcnt1 = 0, mcnt2 = 0;

  task automatic check(input string tag, input val_t got, input val_t want);
    n_checks++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s at cycle %0d: got %0d, expected %0d", tag, cycle, got, want);
    end
  endtask

  // Shift then clip to the signed range of w bits.
  function automatic val_t clip(input val_t s, input int sh, input int w, output bit st);
    val_t v  = s >>> sh;
    val_t mx = (val_t'(1) <<< (w - 1)) - 1;
    val_t mn = -mx - 1;
    st = 1'b0;
    if (v > mx) begin st = 1'b1; return mx; end
    if (v < mn) begin st = 1'b1; return mn; end
    return v;
  endfunction

  task automatic tick();
    bit   ev;
    exp_t e;
    @(posedge clk);
    #1;
    cycle++;
    ev = (q0.size() > 0) && (q0[0].due == cycle);
    if (ev) begin
      e = q0.pop_front(); last0 = e.val; lsat0 = e.sat;
      if (e.sat && mcnt0 < 65535) mcnt0++;
    end
    check("dut0.out_valid", val_t'(ov0), val_t'(ev));
    check("dut0.data", val_t'(signed'(dout0)), last0);
    check("dut0.sat", val_t'(sat0), val_t'(lsat0));
    check("dut0.sat_cnt", val_t'(scnt_dut0), val_t'(mcnt0));
    ev = (q1.size() > 0) && (q1[0].due == cycle);
    if (ev) begin
      e = q1.pop_front(); last1 = e.val; lsat1 = e.sat;
      if (e.sat && mcnt1 < 65535) mcnt1++;
    end
    check("dut1.out_valid", val_t'(ov1), val_t'(ev));
    check("dut1.data", val_t'(signed'(dout1)), last1);
    check("dut1.sat", val_t'(sat1), val_t'(lsat1));
    check("dut1.sat_cnt", val_t'(scnt_dut1), val_t'(mcnt1));
    ev = (q2.size() > 0) && (q2[0].due == cycle);
    if (ev) begin
      e = q2.pop_front(); last2 = e.val; lsat2 = e.sat;
      if (e.sat && mcnt2 < 65535) mcnt2++;
    end
    check("dut2.out_valid", val_t'(ov2), val_t'(ev));
    check("dut2.data", val_t'(signed'(dout2)), last2);
    check("dut2.sat", val_t'(sat2), val_t'(lsat2));
    check("dut2.sat_cnt", val_t'(scnt_dut2), val_t'(mcnt2));
  endtask

  task automatic scramble();
    for (int k = 0; k < 24; k++) data_in[k*32 +: 32] = $urandom;
    for (int k = 0; k < 5; k++) data5[k*32 +: 32] = $urandom;
    ch_en = 24'($urandom);
    en5   = 5'($urandom);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      in_valid = 1'b0;
      iv5      = 1'b0;
      scramble();
      tick();
    end
  endtask

  task automatic drive_main(input logic [767:0] d, input logic [23:0] en);
    exp_t e;
    val_t s = 0;
    bit   st;
    for (int k = 0; k < 24; k++)
      if (en[k]) s += val_t'(signed'(d[k*32 +: 32]));
    e.val = clip(s, 0, 37, st);
    e.sat = st;
    e.due = cycle + 7;
    q0.push_back(e);
    data_in  = d;
    ch_en    = en;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic drive_small(input logic [159:0] d, input logic [4:0] en);
    exp_t e;
    val_t s = 0;
    bit   st;
    for (int k = 0; k < 5; k++)
      if (en[k]) s += val_t'(signed'(d[k*32 +: 32]));
    e.due = cycle + 5;
    e.val = clip(s, 0, 32, st); e.sat = st; q1.push_back(e);
    e.val = clip(s, 3, 32, st); e.sat = st; q2.push_back(e);
    data5 = d;
    en5   = en;
    iv5   = 1'b1;
    tick();
    iv5 = 1'b0;
  endtask

  function automatic logic [31:0] pick32();
    case ($urandom_range(0, 3))
      0:       return 32'h7FFF_FFFF;
      1:       return 32'h8000_0000;
      2:       return 32'($urandom_range(0, 255));
      default: return $urandom;
    endcase
  endfunction

  // Reset acts asynchronously: outputs must already be clear before any clock edge.
  task automatic reset_now();
    rst = 1'b1;
    #1;
    q0.delete(); q1.delete(); q2.delete();
    last0 = 0; last1 = 0; last2 = 0;
    lsat0 = 0; lsat1 = 0; lsat2 = 0;
    mcnt0 = 0; mcnt1 = 0; mcnt2 = 0;
    check("rst.dut0.out_valid", val_t'(ov0), 0);
    check("rst.dut0.data", val_t'(dout0), 0);
    check("rst.dut0.sat", val_t'(sat0), 0);
    check("rst.dut0.sat_cnt", val_t'(scnt_dut0), 0);
    check("rst.dut1.sat_cnt", val_t'(scnt_dut1), 0);
    check("rst.dut1.data", val_t'(dout1), 0);
    check("rst.dut2.data", val_t'(dout2), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [767:0] d;
    logic [159:0] d5;
    rst      = 1'b0;
    in_valid = 1'b0;
    iv5      = 1'b0;
    data_in  = '0;
    ch_en    = '0;
    data5    = '0;
    en5      = '0;
    #2;
    reset_now();
    idle(3);
    rst = 1'b0;
    idle(2);

    // Single pulse, all ones: exactly one result of 24 after 7 cycles.
    drive_main({24{32'd1}}, '1);
    idle(10);

    // Extreme channel values.
    drive_main({24{32'h8000_0000}}, '1);
    drive_main({24{32'h7FFF_FFFF}}, '1);
    idle(8);

    // Only channels 0 and 23 enabled with channel k = k+1, then nothing enabled.
    for (int k = 0; k < 24; k++) d[k*32 +: 32] = 32'(k + 1);
    drive_main(d, 24'h80_0001);
    drive_main(d, 24'h00_0000);
    idle(8);

    // Ten back-to-back samples.
    for (int i = 1; i <= 10; i++) drive_main({24{32'(i)}}, '1);
    idle(8);

    // Random stream with random enables and occasional gaps.
    repeat (40) begin
      for (int k = 0; k < 24; k++) d[k*32 +: 32] = $urandom;
      drive_main(d, 24'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(8);

    // 5-channel instances: saturation with SHIFT 0, in range with SHIFT 3.
    drive_small({5{32'h7FFF_FFFF}}, 5'b11111);
    idle(6);
    repeat (30) begin
      for (int k = 0; k < 5; k++) d5[k*32 +: 32] = pick32();
      drive_small(d5, 5'($urandom));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(6);

    // Reset three cycles after a pulse discards it; a later sample still takes 7 cycles.
    drive_main({24{32'd3}}, '1);
    drive_small({5{32'h7FFF_FFFF}}, 5'b11111);
    tick();
    reset_now();
    idle(2);
    rst = 1'b0;
    idle(12);
    for (int k = 0; k < 24; k++) d[k*32 +: 32] = $urandom;
    drive_main(d, '1);
    idle(10);

    check("drain.q0", val_t'(q0.size()), 0);
    check("drain.q1", val_t'(q1.size()), 0);
    check("drain.q2", val_t'(q2.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
